regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_pkg.sv | 29 ++
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter_wb_fifo.sv | 70 +++++++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: the buffered write
// request record, the per-cycle grant encoding and a destination decode helper.
package regfile_wb_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [2:0] {
    GRANT_NONE,
    GRANT_FORCE,
    GRANT_CORE,
    GRANT_HEAD,
    GRANT_BYPASS
  } grant_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the core writeback, lu handshake and register-file write port
// signals; the arbiter sits on the slave side.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  core_wr_en;
  logic [REG_ADDR_W-1:0] core_rd;
  logic [XLEN-1:0]       core_wdata;
  logic                  core_stall;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0]       lu_wdata;

  logic                  reg_write;
  logic [REG_ADDR_W-1:0] destination_reg;
  logic [XLEN-1:0]       write_data;
  logic [NUM_REGS-1:0]   pending_mask;
  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  core_wr_en, core_rd, core_wdata,
    input  lu_valid, lu_rd, lu_wdata,
    output core_stall, lu_ready,
    output reg_write, destination_reg, write_data,
    output pending_mask, fifo_count
  );

  modport master (
    output core_wr_en, core_rd, core_wdata,
    output lu_valid, lu_rd, lu_wdata,
    input  core_stall, lu_ready,
    input  reg_write, destination_reg, write_data,
    input  pending_mask, fifo_count
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Circular buffer of lu writeback requests with occupancy count, head view and
// per-slot valid/destination vectors used to build the pending mask.
module regfile_wb_arbiter_wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  output wb_req_t               head,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]      entry_vld,
  output logic [REG_ADDR_W-1:0] entry_rd [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Control state only; slot contents are qualified by entry_vld and count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A same-cycle push and pop never share a slot: pop needs a non-empty
      // buffer and push needs a non-full one.
      if (pop) begin
        entry_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        entry_vld[wr_ptr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem[i].rd;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the single-cycle core writeback
// and a buffered long-latency unit, with bounded head wait and x0 suppression.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  regfile_wb_arbiter_if.slave bus
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  wb_req_t               head;
  wb_req_t               lu_req;
  logic [CNT_W-1:0]      count;
  logic [DEPTH-1:0]      entry_vld;
  logic [REG_ADDR_W-1:0] entry_rd [DEPTH];
  logic [WAIT_W-1:0]     wait_cnt;
  logic [NUM_REGS-1:0]   pend;

  logic   fifo_nonempty;
  logic   lu_ready_int;
  logic   lu_fire;
  logic   lu_live;
  logic   core_live;
  logic   force_grant;
  logic   push;
  logic   pop;
  logic   bypass;
  grant_t grant;

  assign fifo_nonempty = (count != '0);
  assign lu_ready_int  = (count < CNT_W'(DEPTH));
  assign lu_fire       = bus.lu_valid && lu_ready_int;
  assign lu_live       = lu_fire && (bus.lu_rd != '0);
  assign core_live     = bus.core_wr_en && (bus.core_rd != '0);
  assign force_grant   = fifo_nonempty && (wait_cnt >= WAIT_W'(MAX_WAIT));
  assign lu_req        = '{rd: bus.lu_rd, data: bus.lu_wdata};

  always_comb begin
    grant = GRANT_NONE;
    if (force_grant) begin
      grant = GRANT_FORCE;
    end else if (core_live) begin
      grant = GRANT_CORE;
    end else if (fifo_nonempty) begin
      grant = GRANT_HEAD;
    end else if (lu_live) begin
      grant = GRANT_BYPASS;
    end
  end

  always_comb begin
    bus.reg_write       = 1'b0;
    bus.destination_reg = '0;
    bus.write_data      = '0;
    bus.core_stall      = 1'b0;
    pop                 = 1'b0;
    bypass              = 1'b0;
    unique case (grant)
      GRANT_FORCE: begin
        bus.core_stall      = 1'b1;
        bus.reg_write       = 1'b1;
        bus.destination_reg = head.rd;
        bus.write_data      = head.data;
        pop                 = 1'b1;
      end
      GRANT_CORE: begin
        bus.reg_write       = 1'b1;
        bus.destination_reg = bus.core_rd;
        bus.write_data      = bus.core_wdata;
      end
      GRANT_HEAD: begin
        bus.reg_write       = 1'b1;
        bus.destination_reg = head.rd;
        bus.write_data      = head.data;
        pop                 = 1'b1;
      end
      GRANT_BYPASS: begin
        bus.reg_write       = 1'b1;
        bus.destination_reg = bus.lu_rd;
        bus.write_data      = bus.lu_wdata;
        bypass              = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // x0 results are accepted by the handshake but never buffered.
  assign push = lu_live && !bypass;

  regfile_wb_arbiter_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_req  (lu_req),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .entry_vld (entry_vld),
    .entry_rd  (entry_rd)
  );

  // Age of the current head, not of individual entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (pop || !fifo_nonempty) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) begin
        pend = pend | rd_onehot(entry_rd[i]);
      end
    end
  end

  assign bus.pending_mask = pend;
  assign bus.fifo_count   = count;
  assign bus.lu_ready     = lu_ready_int;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for the register-file writeback arbiter: directed vector table,
// asynchronous flush sequence, and randomized traffic against a queue model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int TB_DEPTH    = 2;
  localparam int TB_MAX_WAIT = 4;
  localparam int TB_CNT_W    = $clog2(TB_DEPTH) + 1;
  localparam int N_VEC       = 22;
  localparam int N_RAND      = 2000;

  typedef struct packed {
    logic                rw;
    logic [4:0]          rd;
    logic [31:0]         data;
    logic                stall;
    logic                ready;
    logic [31:0]         mask;
    logic [TB_CNT_W-1:0] cnt;
  } out_t;

  typedef struct {
    logic        cwe;
    logic [4:0]  crd;
    logic [31:0] cd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    out_t        exp;
  } vec_t;

  logic clock;
  logic reset_n;

  regfile_wb_arbiter_if #(.DEPTH(TB_DEPTH)) bus ();

  regfile_wb_arbiter #(
    .DEPTH    (TB_DEPTH),
    .MAX_WAIT (TB_MAX_WAIT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  wb_req_t     mq [$];
  int          mage;
  logic [31:0] rf_model [32];
  logic [31:0] rf_dut   [32];
  vec_t        vecs     [N_VEC];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic out_t mk_out(logic [31:0] rw, logic [31:0] rd, logic [31:0] data,
                                  logic [31:0] st, logic [31:0] rdy, logic [31:0] mask,
                                  logic [31:0] cnt);
    out_t o;
    o.rw    = rw[0];
    o.rd    = rd[4:0];
    o.data  = data;
    o.stall = st[0];
    o.ready = rdy[0];
    o.mask  = mask;
    o.cnt   = cnt[TB_CNT_W-1:0];
    return o;
  endfunction

  function automatic vec_t mk(logic [31:0] cwe, logic [31:0] crd, logic [31:0] cd,
                              logic [31:0] lv, logic [31:0] lrd, logic [31:0] ld, out_t e);
    vec_t v;
    v.cwe = cwe[0];
    v.crd = crd[4:0];
    v.cd  = cd;
    v.lv  = lv[0];
    v.lrd = lrd[4:0];
    v.ld  = ld;
    v.exp = e;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.rw    = bus.reg_write;
    o.rd    = bus.destination_reg;
    o.data  = bus.write_data;
    o.stall = bus.core_stall;
    o.ready = bus.lu_ready;
    o.mask  = bus.pending_mask;
    o.cnt   = bus.fifo_count;
    return o;
  endfunction

  task automatic drive(logic [31:0] cwe, logic [31:0] crd, logic [31:0] cd,
                       logic [31:0] lv, logic [31:0] lrd, logic [31:0] ld);
    bus.core_wr_en = cwe[0];
    bus.core_rd    = crd[4:0];
    bus.core_wdata = cd;
    bus.lu_valid   = lv[0];
    bus.lu_rd      = lrd[4:0];
    bus.lu_wdata   = ld;
  endtask

  task automatic check_out(string nm, out_t act, out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got rw=%0b rd=%0d data=%h stall=%0b ready=%0b mask=%h cnt=%0d, want rw=%0b rd=%0d data=%h stall=%0b ready=%0b mask=%h cnt=%0d",
               nm, act.rw, act.rd, act.data, act.stall, act.ready, act.mask, act.cnt,
               exp.rw, exp.rd, exp.data, exp.stall, exp.ready, exp.mask, exp.cnt);
    end
  endtask

  task automatic check_val(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference: arbitration rules applied to a queue of buffered results.
  task automatic model_eval(input logic cwe, input logic [4:0] crd, input logic [31:0] cd,
                            input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                            output out_t e, output logic do_pop, output logic do_push);
    int   cnt;
    logic lu_real;
    logic core_real;
    logic byp;
    cnt       = mq.size();
    e         = '0;
    e.ready   = (cnt < TB_DEPTH);
    e.cnt     = cnt[TB_CNT_W-1:0];
    foreach (mq[i]) e.mask[mq[i].rd] = 1'b1;
    lu_real   = lv && e.ready && (lrd != 5'd0);
    core_real = cwe && (crd != 5'd0);
    do_pop    = 1'b0;
    byp       = 1'b0;
    if (cnt > 0 && mage >= TB_MAX_WAIT) begin
      e.stall = 1'b1; e.rw = 1'b1; e.rd = mq[0].rd; e.data = mq[0].data; do_pop = 1'b1;
    end else if (core_real) begin
      e.rw = 1'b1; e.rd = crd; e.data = cd;
    end else if (cnt > 0) begin
      e.rw = 1'b1; e.rd = mq[0].rd; e.data = mq[0].data; do_pop = 1'b1;
    end else if (lu_real) begin
      e.rw = 1'b1; e.rd = lrd; e.data = ld; byp = 1'b1;
    end
    do_push = lu_real && !byp;
  endtask

  task automatic model_commit(input logic [4:0] lrd, input logic [31:0] ld,
                              input logic do_pop, input logic do_push);
    int cnt;
    cnt = mq.size();
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back('{rd: lrd, data: ld});
    if (do_pop || cnt == 0) mage = 0;
    else if (mage < TB_MAX_WAIT) mage = mage + 1;
  endtask

  initial begin
    logic        cwe, lv, mpop, mpush, prev_stall, prev_hold;
    logic [4:0]  crd, lrd;
    logic [31:0] cd, ld;
    int          pct;
    out_t        e;

    vecs[0]  = mk(0, 0, 0,        0, 0, 0,            mk_out(0, 0, 0,            0, 1, 0,     0));
    vecs[1]  = mk(0, 0, 0,        1, 5, 32'hDEADBEEF, mk_out(1, 5, 32'hDEADBEEF, 0, 1, 0,     0));
    vecs[2]  = mk(1, 3, 'h300,    1, 7, 'h11,         mk_out(1, 3, 'h300,        0, 1, 0,     0));
    vecs[3]  = mk(1, 3, 'h301,    1, 8, 'h22,         mk_out(1, 3, 'h301,        0, 1, 'h80,  1));
    vecs[4]  = mk(1, 3, 'h302,    0, 0, 0,            mk_out(1, 3, 'h302,        0, 0, 'h180, 2));
    vecs[5]  = mk(1, 3, 'h303,    0, 0, 0,            mk_out(1, 3, 'h303,        0, 0, 'h180, 2));
    vecs[6]  = mk(1, 3, 'h304,    0, 0, 0,            mk_out(1, 3, 'h304,        0, 0, 'h180, 2));
    vecs[7]  = mk(1, 3, 'h305,    0, 0, 0,            mk_out(1, 7, 'h11,         1, 0, 'h180, 2));
    vecs[8]  = mk(1, 3, 'h305,    0, 0, 0,            mk_out(1, 3, 'h305,        0, 1, 'h100, 1));
    vecs[9]  = mk(1, 3, 'h306,    0, 0, 0,            mk_out(1, 3, 'h306,        0, 1, 'h100, 1));
    vecs[10] = mk(1, 3, 'h307,    0, 0, 0,            mk_out(1, 3, 'h307,        0, 1, 'h100, 1));
    vecs[11] = mk(1, 3, 'h308,    0, 0, 0,            mk_out(1, 3, 'h308,        0, 1, 'h100, 1));
    vecs[12] = mk(1, 3, 'h309,    0, 0, 0,            mk_out(1, 8, 'h22,         1, 1, 'h100, 1));
    vecs[13] = mk(1, 3, 'h309,    1, 9, 'h99,         mk_out(1, 3, 'h309,        0, 1, 0,     0));
    vecs[14] = mk(1, 3, 'h30A,    1, 10, 'hAA,        mk_out(1, 3, 'h30A,        0, 1, 'h200, 1));
    vecs[15] = mk(0, 0, 0,        0, 0, 0,            mk_out(1, 9, 'h99,         0, 0, 'h600, 2));
    vecs[16] = mk(0, 0, 0,        0, 0, 0,            mk_out(1, 10, 'hAA,        0, 1, 'h400, 1));
    vecs[17] = mk(0, 0, 0,        0, 0, 0,            mk_out(0, 0, 0,            0, 1, 0,     0));
    vecs[18] = mk(1, 0, 'h555,    1, 0, 'h777,        mk_out(0, 0, 0,            0, 1, 0,     0));
    vecs[19] = mk(0, 0, 0,        0, 0, 0,            mk_out(0, 0, 0,            0, 1, 0,     0));
    vecs[20] = mk(1, 0, 'h555,    1, 12, 'hC,         mk_out(1, 12, 'hC,         0, 1, 0,     0));
    vecs[21] = mk(0, 0, 0,        0, 0, 0,            mk_out(0, 0, 0,            0, 1, 0,     0));

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #3 check_out("reset_hold", sample(), mk_out(0, 0, 0, 0, 1, 0, 0));
    reset_n = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      @(posedge clock);
      #2 drive(vecs[i].cwe, vecs[i].crd, vecs[i].cd, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
      #1 check_out($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    // Fill the buffer behind a busy core, then flush it with an async reset.
    @(posedge clock);
    #2 drive(1, 3, 'h400, 1, 20, 'h20);
    #1 check_out("fill0", sample(), mk_out(1, 3, 'h400, 0, 1, 0, 0));
    @(posedge clock);
    #2 drive(1, 3, 'h401, 1, 21, 'h21);
    #1 check_out("fill1", sample(), mk_out(1, 3, 'h401, 0, 1, 32'h0010_0000, 1));
    @(posedge clock);
    #2 drive(0, 0, 0, 0, 0, 0);
    #1 check_out("full_pre_reset", sample(), mk_out(1, 20, 'h20, 0, 0, 32'h0030_0000, 2));
    reset_n = 1'b0;
    #1 check_out("async_flush", sample(), mk_out(0, 0, 0, 0, 1, 0, 0));
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #3 check_out($sformatf("post_flush%0d", i), sample(), mk_out(0, 0, 0, 0, 1, 0, 0));
    end

    // Randomized traffic against the queue model.
    reset_n = 1'b0;
    mq.delete();
    mage = 0;
    for (int r = 0; r < 32; r++) begin
      rf_model[r] = '0;
      rf_dut[r]   = '0;
    end
    @(posedge clock);
    #2 reset_n = 1'b1;
    prev_stall = 1'b0;
    prev_hold  = 1'b0;
    cwe = 1'b0; crd = '0; cd = '0; lv = 1'b0; lrd = '0; ld = '0;
    for (int n = 0; n < N_RAND; n++) begin
      @(posedge clock);
      #2;
      case ((n / 500) % 4)
        0:       pct = 20;
        1:       pct = 60;
        2:       pct = 90;
        default: pct = 100;
      endcase
      if (!prev_stall) begin
        cwe = ($urandom_range(0, 99) < pct);
        crd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        cd  = $urandom;
      end
      if (!prev_hold) begin
        lv  = ($urandom_range(0, 99) < 45);
        lrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        ld  = $urandom;
      end
      drive(cwe, crd, cd, lv, lrd, ld);
      #1;
      model_eval(cwe, crd, cd, lv, lrd, ld, e, mpop, mpush);
      check_out($sformatf("rand%0d", n), sample(), e);
      @(negedge clock);
      if (bus.reg_write) rf_dut[bus.destination_reg] = bus.write_data;
      if (e.rw) rf_model[e.rd] = e.data;
      model_commit(lrd, ld, mpop, mpush);
      prev_stall = e.stall;
      prev_hold  = lv && !e.ready;
    end
    for (int r = 0; r < 32; r++) begin
      check_val($sformatf("regfile_x%0d", r), rf_dut[r], rf_model[r]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
